// File: rtl/uart_transport_pkg.sv
// Shared definitions for the UART transport: receiver state encodings,
// frame geometry and the default oversampling ratio.
package uart_transport_pkg;

    // Data bits per 8N1 frame
    localparam int DATA_BITS = 8;

    // Width of the data-bit index
    localparam int BITPOS_W = $clog2(DATA_BITS);

    // clken ticks per bit period unless overridden
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Receiver FSM encodings; the remaining 3-bit codes are illegal and recover to IDLE
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin. Both flops reset to 1,
// the idle level of the line, so leaving reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronization into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver. Oversamples the synchronized rx line on clken ticks,
// checks the start bit at its midpoint, samples each data bit and the stop bit
// one bit period apart, and hands bytes to the consumer via rdy/rdy_clr.
module uart_receiver
    import uart_transport_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 clken,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    // Counter value at the start-bit midpoint and at one full bit period
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BITPOS_W-1:0] BITPOS_LAST = BITPOS_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [BITPOS_W-1:0]  bitpos_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 rdy_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // Free-running increment; each state transition overrides it with zero
    assign cnt_d = cnt_q + 1'b1;

    // Receiver FSM, sample counter, shift register and consumer-facing flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bitpos_q    <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Consumer acknowledge works regardless of clken; a byte completing
            // in the same cycle overrides it further down.
            if (rdy_clr) begin
                rdy_q     <= 1'b0;
                overrun_q <= 1'b0;
            end

            if (clken) begin
                cnt_q <= cnt_d;
                case (state_q)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state_q <= ST_START;
                            cnt_q   <= '0;
                        end
                    end
                    ST_START: begin
                        if (cnt_q == CNT_MID) begin
                            cnt_q <= '0;
                            if (!rx_s) begin
                                state_q  <= ST_DATA;
                                bitpos_q <= '0;
                            end else begin
                                // Line went back high before midpoint: noise, not a start bit
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q             <= '0;
                            shift_q[bitpos_q] <= rx_s;
                            if (bitpos_q == BITPOS_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                bitpos_q <= bitpos_q + 1'b1;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (rx_s) begin
                                dout_q      <= shift_q;
                                rdy_q       <= 1'b1;
                                frame_err_q <= 1'b0;
                                // An acknowledge in this very cycle consumed the old byte
                                overrun_q   <= rdy_q & ~rdy_clr;
                                state_q     <= ST_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_WAIT_HIGH;
                            end
                        end
                    end
                    ST_WAIT_HIGH: begin
                        // A break holds the line low; only a return to idle re-arms
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign dout      = dout_q;
    assign rdy       = rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver. A single process drives rx, clken
// (one pulse every 4 clk) and rdy_clr on falling clk edges; expected outputs
// come from a frame-level model of the consumer-visible flags.
module tb_uart_receiver;

    localparam int OS = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       clken;
    logic       rdy_clr;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int errors;
    int checks;

    // Frame-level model of the consumer-visible state
    logic [7:0] exp_dout;
    logic       exp_rdy;
    logic       exp_ferr;
    logic       exp_ovr;

    // rdy captured just before / one clk after the stop-bit sampling tick
    logic rdy_pre;
    logic rdy_post;

    uart_receiver #(
        .OVERSAMPLE (OS),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .clken     (clken),
        .rdy_clr   (rdy_clr),
        .dout      (dout),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        exp_dout = 8'h00; exp_rdy = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic model_clr();
        exp_rdy = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic clr);
        if (stop_bit) begin
            exp_ovr  = exp_rdy & ~clr;
            exp_rdy  = 1'b1;
            exp_dout = b;
            exp_ferr = 1'b0;
        end else begin
            exp_ferr = 1'b1;
            if (clr) model_clr();
        end
    endtask

    // ---------------- drivers ----------------
    // One clken period: pulse on the first clk, idle for three. Starts and ends on a negedge.
    task automatic do_tick();
        clken = 1'b1;
        @(negedge clk);
        clken   = 1'b0;
        rdy_clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        for (int k = 0; k < n; k++) do_tick();
    endtask

    // Whole 8N1 frame; optional rdy_clr on the tick that samples the stop bit.
    // The start edge is seen on tick 2 of the frame, so the stop bit is sampled
    // on tick OS/2+2 of the stop-bit period.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic clr_at_done);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int t = 1; t <= OS; t++) begin
                if (i == 9 && t == OS / 2 + 2) begin
                    clken   = 1'b1;
                    rdy_clr = clr_at_done;
                    rdy_pre = rdy;
                    @(negedge clk);
                    rdy_post = rdy;
                    clken    = 1'b0;
                    rdy_clr  = 1'b0;
                    repeat (3) @(negedge clk);
                end else begin
                    do_tick();
                end
            end
        end
        model_frame(b, stop_bit, clr_at_done);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1; clken = 1'b0; rdy_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (dout !== 8'h00)     begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++; if (rdy !== 1'b0)       begin errors++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
        checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        rst_n = 1'b1;
        idle(4);
        checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL post_reset_busy got=%b exp=0", rx_busy); end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 1'b0);
        checks++; if (rdy_pre !== 1'b0)  begin errors++; $display("FAIL basic_rdy_before got=%b exp=0", rdy_pre); end
        checks++; if (rdy_post !== 1'b1) begin errors++; $display("FAIL basic_rdy_1clk got=%b exp=1", rdy_post); end
        idle(4);
        checks++; if (dout !== 8'hA5)     begin errors++; $display("FAIL basic_dout got=%h exp=a5", dout); end
        checks++; if (rdy !== exp_rdy)    begin errors++; $display("FAIL basic_rdy got=%b exp=%b", rdy, exp_rdy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL basic_ovr got=%b exp=0", overrun); end
        checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL basic_busy got=%b exp=0", rx_busy); end
        // Acknowledge while clken is low
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
        model_clr();
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL basic_clr_rdy got=%b exp=0", rdy); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        for (int k = 0; k < 3; k++) do_tick();
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during got=%b exp=1", rx_busy); end
        idle(12);
        checks++; if (rx_busy !== 1'b0)      begin errors++; $display("FAIL glitch_busy_after got=%b exp=0", rx_busy); end
        checks++; if (rdy !== 1'b0)          begin errors++; $display("FAIL glitch_rdy got=%b exp=0", rdy); end
        checks++; if (dout !== exp_dout)     begin errors++; $display("FAIL glitch_dout got=%h exp=%h", dout, exp_dout); end
        checks++; if (frame_err !== exp_ferr) begin errors++; $display("FAIL glitch_ferr got=%b exp=%b", frame_err, exp_ferr); end
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0, 1'b0);
        // Break: hold the line low for 40 bit times
        rx = 1'b0;
        for (int k = 0; k < 40 * OS; k++) do_tick();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
        checks++; if (rdy !== 1'b0)       begin errors++; $display("FAIL ferr_rdy got=%b exp=0", rdy); end
        checks++; if (dout !== exp_dout)  begin errors++; $display("FAIL ferr_dout_kept got=%h exp=%h", dout, exp_dout); end
        checks++; if (rx_busy !== 1'b1)   begin errors++; $display("FAIL break_busy got=%b exp=1", rx_busy); end
        idle(8);
        checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL break_release_busy got=%b exp=0", rx_busy); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky got=%b exp=1", frame_err); end
        send_frame(8'h11, 1'b1, 1'b0);
        idle(4);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_cleared got=%b exp=0", frame_err); end
        checks++; if (dout !== 8'h11)     begin errors++; $display("FAIL ferr_next_dout got=%h exp=11", dout); end
        checks++; if (rdy !== 1'b1)       begin errors++; $display("FAIL ferr_next_rdy got=%b exp=1", rdy); end
        rdy_clr = 1'b1; @(negedge clk); rdy_clr = 1'b0; model_clr();
    endtask

    task automatic test_overrun();
        send_frame(8'h01, 1'b1, 1'b0);
        idle(4);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first got=%b exp=0", overrun); end
        send_frame(8'h02, 1'b1, 1'b0);
        idle(4);
        checks++; if (dout !== 8'h02)   begin errors++; $display("FAIL ovr_dout got=%h exp=02", dout); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        checks++; if (rdy !== 1'b1)     begin errors++; $display("FAIL ovr_rdy got=%b exp=1", rdy); end
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
        model_clr();
        checks++; if (rdy !== 1'b0)     begin errors++; $display("FAIL ovr_clr_rdy got=%b exp=0", rdy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr_ovr got=%b exp=0", overrun); end
        idle(2);
    endtask

    task automatic test_clr_coincide();
        send_frame(8'h44, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h7E, 1'b1, 1'b1);
        checks++; if (rdy_pre !== 1'b1) begin errors++; $display("FAIL coin_rdy_before got=%b exp=1", rdy_pre); end
        idle(4);
        checks++; if (rdy !== 1'b1)     begin errors++; $display("FAIL coin_rdy got=%b exp=1", rdy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coin_ovr got=%b exp=0", overrun); end
        checks++; if (dout !== 8'h7E)   begin errors++; $display("FAIL coin_dout got=%h exp=7e", dout); end
        rdy_clr = 1'b1; @(negedge clk); rdy_clr = 1'b0; model_clr();
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        // Leave every flag set so the reset is observable
        send_frame(8'h12, 1'b1, 1'b0);
        idle(3);
        send_frame(8'h34, 1'b1, 1'b0);
        idle(3);
        send_frame(8'h56, 1'b0, 1'b0);
        idle(4);
        bits = {1'b1, 8'hFF, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int t = 1; t <= OS; t++) begin
                if (i == 5 && t == OS / 2) begin
                    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", rx_busy); end
                    rst_n = 1'b0;
                    #1;
                    model_reset();
                    checks++; if (dout !== 8'h00)     begin errors++; $display("FAIL rstmid_dout got=%h exp=00", dout); end
                    checks++; if (rdy !== 1'b0)       begin errors++; $display("FAIL rstmid_rdy got=%b exp=0", rdy); end
                    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
                    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rstmid_ovr got=%b exp=0", overrun); end
                    checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy got=%b exp=0", rx_busy); end
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                do_tick();
            end
        end
        idle(8);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rstmid_no_byte got=%b exp=0", rdy); end
        send_frame(8'h55, 1'b1, 1'b0);
        idle(4);
        checks++; if (dout !== 8'h55)     begin errors++; $display("FAIL rstmid_next_dout got=%h exp=55", dout); end
        checks++; if (rdy !== 1'b1)       begin errors++; $display("FAIL rstmid_next_rdy got=%b exp=1", rdy); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rstmid_next_ovr got=%b exp=0", overrun); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop_bit;
        logic       clr_done;
        for (int n = 0; n < 16; n++) begin
            b        = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 4) != 0);
            clr_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                rdy_clr = 1'b1; @(negedge clk); rdy_clr = 1'b0; model_clr();
            end
            send_frame(b, stop_bit, clr_done);
            idle($urandom_range(3, 12));
            checks++; if (dout !== exp_dout)      begin errors++; $display("FAIL rand%0d_dout got=%h exp=%h", n, dout, exp_dout); end
            checks++; if (rdy !== exp_rdy)        begin errors++; $display("FAIL rand%0d_rdy got=%b exp=%b", n, rdy, exp_rdy); end
            checks++; if (frame_err !== exp_ferr) begin errors++; $display("FAIL rand%0d_ferr got=%b exp=%b", n, frame_err, exp_ferr); end
            checks++; if (overrun !== exp_ovr)    begin errors++; $display("FAIL rand%0d_ovr got=%b exp=%b", n, overrun, exp_ovr); end
            checks++; if (rx_busy !== 1'b0)       begin errors++; $display("FAIL rand%0d_busy got=%b exp=0", n, rx_busy); end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rdy_pre  = 1'b0;
        rdy_post = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_clr_coincide();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
